// File: rtl/alu_pkg.sv
// Shared types and constants for the 32-bit single-cycle ALU.
// Comparator opcodes are only live when ALU_CMP_EN is defined.
package alu_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [3:0] {
      ADD  = 4'b0000,
      SUB  = 4'b0001,
      SRL  = 4'b0010,
      SRA  = 4'b0011,
      SLL  = 4'b0100,
      XOR  = 4'b0101,
      OR   = 4'b0110,
      AND  = 4'b0111,
      CMPU = 4'b1000,
      CMPS = 4'b1001
   } alu_op_e;

   localparam logic [2:0] GES_GT   = 3'b100;
   localparam logic [2:0] GES_EQ   = 3'b010;
   localparam logic [2:0] GES_LT   = 3'b001;
   localparam logic [2:0] GES_NONE = 3'b000;

   localparam logic [1:0] SH_SRL  = 2'b00;
   localparam logic [1:0] SH_SRA  = 2'b01;
   localparam logic [1:0] SH_SLL  = 2'b10;
   localparam logic [1:0] SH_NONE = 2'b11;

   // Map compare outcomes onto the one-hot greater/equal/smaller vector.
   function automatic logic [2:0] ges_encode(input logic i_gt, input logic i_eq);
      logic [2:0] w_ges;
      if (i_gt) begin
         w_ges = GES_GT;
      end else if (i_eq) begin
         w_ges = GES_EQ;
      end else begin
         w_ges = GES_LT;
      end
      return w_ges;
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SRL / SRA / SLL.
// Select SH_NONE yields zero so unrelated opcodes see a quiet datapath.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] i_data,
   input  logic [4:0]        i_amount,
   input  logic [1:0]        i_sel,
   output logic [DATA_W-1:0] o_data
);

   // Direction / fill select.
   always_comb begin
      o_data = {DATA_W{1'b0}};
      case (i_sel)
         SH_SRL:  o_data = i_data >> i_amount;
         SH_SRA:  o_data = DATA_W'($signed(i_data) >>> i_amount);
         SH_SLL:  o_data = i_data << i_amount;
         default: o_data = {DATA_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/alu.sv
// 32-bit integer ALU, one registered result per clock, 1-cycle latency.
// Macro ALU_CMP_EN builds the unsigned/signed comparator driving GES.
module alu
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] Arg1,
   input  logic [DATA_W-1:0] Arg2,
   input  logic [3:0]        ALU_Control,
   output logic [DATA_W-1:0] ALUResult,
   output logic [2:0]        GES
);

   alu_op_e           w_op;
   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_diff;
   logic [DATA_W-1:0] w_shift;
   logic [1:0]        w_sh_sel;
   logic [DATA_W-1:0] w_result_nxt;
   logic [DATA_W-1:0] r_result;

   assign w_op   = alu_op_e'(ALU_Control);
   assign w_sum  = Arg1 + Arg2;
   assign w_diff = Arg1 - Arg2;

   // Shifter select derived from opcode.
   always_comb begin
      w_sh_sel = SH_NONE;
      case (w_op)
         SRL:     w_sh_sel = SH_SRL;
         SRA:     w_sh_sel = SH_SRA;
         SLL:     w_sh_sel = SH_SLL;
         default: w_sh_sel = SH_NONE;
      endcase
   end

   alu_shifter u_shifter (
      .i_data   (Arg1),
      .i_amount (Arg2[4:0]),
      .i_sel    (w_sh_sel),
      .o_data   (w_shift)
   );

   // Result mux; compares and reserved codes produce zero.
   always_comb begin
      w_result_nxt = {DATA_W{1'b0}};
      case (w_op)
         ADD:         w_result_nxt = w_sum;
         SUB:         w_result_nxt = w_diff;
         SRL,
         SRA,
         SLL:         w_result_nxt = w_shift;
         XOR:         w_result_nxt = Arg1 ^ Arg2;
         OR:          w_result_nxt = Arg1 | Arg2;
         AND:         w_result_nxt = Arg1 & Arg2;
         default:     w_result_nxt = {DATA_W{1'b0}};
      endcase
   end

   // Result register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= {DATA_W{1'b0}};
      end else begin
         r_result <= w_result_nxt;
      end
   end

   assign ALUResult = r_result;

`ifdef ALU_CMP_EN
   logic [2:0] w_ges_nxt;
   logic [2:0] r_ges;

   // Comparator; only CMPU/CMPS raise a flag.
   always_comb begin
      w_ges_nxt = GES_NONE;
      case (w_op)
         CMPU:    w_ges_nxt = ges_encode(Arg1 > Arg2, Arg1 == Arg2);
         CMPS:    w_ges_nxt = ges_encode($signed(Arg1) > $signed(Arg2), Arg1 == Arg2);
         default: w_ges_nxt = GES_NONE;
      endcase
   end

   // Flag register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ges <= GES_NONE;
      end else begin
         r_ges <= w_ges_nxt;
      end
   end

   assign GES = r_ges;
`else
   assign GES = GES_NONE;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed and random self-checking bench for alu.
// Expected flags follow ALU_CMP_EN as seen by this compile.
module tb_alu;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] Arg1;
   logic [31:0] Arg2;
   logic [3:0]  ALU_Control;
   logic [31:0] ALUResult;
   logic [2:0]  GES;

   int n_checks;
   int n_fail;
   bit cmp_en;

   alu dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Arg1        (Arg1),
      .Arg2        (Arg2),
      .ALU_Control (ALU_Control),
      .ALUResult   (ALUResult),
      .GES         (GES)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive at the falling edge, then sample 1ns after the capturing rising edge.
   task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      ALU_Control = op;
      Arg1 = a;
      Arg2 = b;
      @(posedge clk);
      #1;
   endtask

   // Independent reference: signed compare via sign-bit flip, SRA via fill mask.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic [2:0] ges);
      logic [4:0]  sh;
      logic [31:0] fa;
      logic [31:0] fb;
      sh  = b[4:0];
      res = 32'h0;
      ges = 3'b000;
      case (op)
         4'd0: res = a + b;
         4'd1: res = a + ~b + 32'd1;
         4'd2: res = a >> sh;
         4'd3: res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         4'd4: res = a << sh;
         4'd5: res = a ^ b;
         4'd6: res = a | b;
         4'd7: res = a & b;
         4'd8: if (cmp_en) ges = (a == b) ? 3'b010 : ((a > b) ? 3'b100 : 3'b001);
         4'd9: begin
            fa = a ^ 32'h8000_0000;
            fb = b ^ 32'h8000_0000;
            if (cmp_en) ges = (fa == fb) ? 3'b010 : ((fa > fb) ? 3'b100 : 3'b001);
         end
         default: res = 32'h0;
      endcase
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      ALU_Control = 4'd0;
      Arg1 = 32'd0;
      Arg2 = 32'd0;
      #1;
      n_checks++;
      if (ALUResult !== 32'h0 || GES !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_initial: got %h/%b expected 00000000/000", ALUResult, GES);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive_op(4'd0, 32'd5, 32'd7);
      n_checks++;
      if (ALUResult !== 32'd12) begin
         n_fail++;
         $display("FAIL reset_preload: got %h expected 0000000c", ALUResult);
      end
      // Assert reset mid-cycle, away from any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ALUResult !== 32'h0 || GES !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_async: got %h/%b expected 00000000/000", ALUResult, GES);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (ALUResult !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h expected 00000000", ALUResult);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_op(4'd0, 32'd5, 32'd7);
      n_checks++;
      if (ALUResult !== 32'd12 || GES !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_release_add: got %h/%b expected 0000000c/000", ALUResult, GES);
      end
   endtask

   task automatic test_arith();
      drive_op(4'd0, 32'hFFFF_FFFF, 32'd1);
      n_checks++;
      if (ALUResult !== 32'h0 || GES !== 3'b000) begin
         n_fail++;
         $display("FAIL add_wrap: got %h/%b expected 00000000/000", ALUResult, GES);
      end
      drive_op(4'd1, 32'd0, 32'd1);
      n_checks++;
      if (ALUResult !== 32'hFFFF_FFFF || GES !== 3'b000) begin
         n_fail++;
         $display("FAIL sub_wrap: got %h/%b expected ffffffff/000", ALUResult, GES);
      end
      drive_op(4'd1, 32'd100, 32'd58);
      n_checks++;
      if (ALUResult !== 32'd42) begin
         n_fail++;
         $display("FAIL sub_basic: got %h expected 0000002a", ALUResult);
      end
   endtask

   task automatic test_shifts();
      drive_op(4'd2, 32'h8000_0010, 32'h0000_0024);
      n_checks++;
      if (ALUResult !== 32'h0800_0001 || GES !== 3'b000) begin
         n_fail++;
         $display("FAIL srl: got %h/%b expected 08000001/000", ALUResult, GES);
      end
      drive_op(4'd3, 32'h8000_0010, 32'h0000_0024);
      n_checks++;
      if (ALUResult !== 32'hF800_0001) begin
         n_fail++;
         $display("FAIL sra: got %h expected f8000001", ALUResult);
      end
      drive_op(4'd4, 32'h8000_0010, 32'h0000_0024);
      n_checks++;
      if (ALUResult !== 32'h0000_0100) begin
         n_fail++;
         $display("FAIL sll: got %h expected 00000100", ALUResult);
      end
      drive_op(4'd3, 32'h8765_4321, 32'hFFFF_FFE0);
      n_checks++;
      if (ALUResult !== 32'h8765_4321) begin
         n_fail++;
         $display("FAIL sra_zero_amount: got %h expected 87654321", ALUResult);
      end
      drive_op(4'd2, 32'h8000_0000, 32'h0000_001F);
      n_checks++;
      if (ALUResult !== 32'h0000_0001) begin
         n_fail++;
         $display("FAIL srl_max: got %h expected 00000001", ALUResult);
      end
   endtask

   task automatic test_logic();
      drive_op(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00);
      n_checks++;
      if (ALUResult !== 32'h0FF0_0FF0) begin
         n_fail++;
         $display("FAIL xor: got %h expected 0ff00ff0", ALUResult);
      end
      drive_op(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00);
      n_checks++;
      if (ALUResult !== 32'hFFF0_FFF0) begin
         n_fail++;
         $display("FAIL or: got %h expected fff0fff0", ALUResult);
      end
      drive_op(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00);
      n_checks++;
      if (ALUResult !== 32'hF000_F000 || GES !== 3'b000) begin
         n_fail++;
         $display("FAIL and: got %h/%b expected f000f000/000", ALUResult, GES);
      end
   endtask

   task automatic test_compare();
      logic [2:0] exp_u;
      logic [2:0] exp_s;
      logic [2:0] exp_e;
      exp_u = cmp_en ? 3'b100 : 3'b000;
      exp_s = cmp_en ? 3'b001 : 3'b000;
      exp_e = cmp_en ? 3'b010 : 3'b000;
      drive_op(4'd8, 32'hFFFF_FFFF, 32'h0000_0001);
      n_checks++;
      if (GES !== exp_u || ALUResult !== 32'h0) begin
         n_fail++;
         $display("FAIL cmpu_gt: got %b/%h expected %b/00000000", GES, ALUResult, exp_u);
      end
      drive_op(4'd9, 32'hFFFF_FFFF, 32'h0000_0001);
      n_checks++;
      if (GES !== exp_s || ALUResult !== 32'h0) begin
         n_fail++;
         $display("FAIL cmps_lt: got %b/%h expected %b/00000000", GES, ALUResult, exp_s);
      end
      drive_op(4'd8, 32'h1234_5678, 32'h1234_5678);
      n_checks++;
      if (GES !== exp_e || ALUResult !== 32'h0) begin
         n_fail++;
         $display("FAIL cmpu_eq: got %b/%h expected %b/00000000", GES, ALUResult, exp_e);
      end
      drive_op(4'd9, 32'h8000_0000, 32'h8000_0000);
      n_checks++;
      if (GES !== exp_e || ALUResult !== 32'h0) begin
         n_fail++;
         $display("FAIL cmps_eq: got %b/%h expected %b/00000000", GES, ALUResult, exp_e);
      end
   endtask

   task automatic test_reserved();
      drive_op(4'd15, 32'hDEAD_BEEF, 32'h1234_5678);
      n_checks++;
      if (ALUResult !== 32'h0 || GES !== 3'b000) begin
         n_fail++;
         $display("FAIL reserved_1111: got %h/%b expected 00000000/000", ALUResult, GES);
      end
      drive_op(4'd10, 32'hFFFF_FFFF, 32'h0000_0001);
      n_checks++;
      if (ALUResult !== 32'h0 || GES !== 3'b000) begin
         n_fail++;
         $display("FAIL reserved_1010: got %h/%b expected 00000000/000", ALUResult, GES);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic [2:0]  exp_ges;
      int          errs;
      errs = 0;
      for (int op = 0; op < 16; op++) begin
         for (int k = 0; k < 300; k++) begin
            a = $urandom();
            b = (k % 7 == 0) ? a : $urandom();
            model(4'(op), a, b, exp_res, exp_ges);
            drive_op(4'(op), a, b);
            n_checks++;
            if (ALUResult !== exp_res || GES !== exp_ges) begin
               n_fail++;
               errs++;
               if (errs <= 10)
                  $display("FAIL b2b op=%0d a=%h b=%h: got %h/%b expected %h/%b",
                           op, a, b, ALUResult, GES, exp_res, exp_ges);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
`ifdef ALU_CMP_EN
      cmp_en = 1'b1;
`else
      cmp_en = 1'b0;
`endif
      test_reset();
      test_arith();
      test_shifts();
      test_logic();
      test_compare();
      test_reserved();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
